// File: rtl/riscv_pkg.sv
// Shared types and constants for the sequential RISC-V core front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, Decode handshake, redirect and fault.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fetch_entry_t      wdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output fetch_entry_t      head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign head    = r_mem[r_rd_ptr];
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers words for Decode,
// and handles redirects by flushing the buffer and dropping in-flight responses.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter int unsigned     CNT_W      = 2
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master bus
);

  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_outstanding_next;
  logic [CNT_W-1:0] w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;
  logic            w_req_valid;
  logic            w_flush;
  logic            w_rsp_push;
  logic            w_credit;
  logic            w_accept;
  logic            w_misaligned;
  logic            w_redirect_ok;

  assign w_credit      = (SUM_W'(w_fifo_count) + SUM_W'(r_outstanding)) < SUM_W'(FIFO_DEPTH);
  assign w_accept      = w_req_valid && bus.imem_req_ready;
  assign w_misaligned  = (bus.redirect_pc[1:0] != 2'b00);
  assign w_redirect_ok = (r_state == RUN) && bus.redirect_valid && !w_misaligned;
  assign w_outstanding_next = r_outstanding + CNT_W'(w_accept) - CNT_W'(bus.imem_rsp_valid);
  assign w_wdata       = '{instr: bus.imem_rsp_data, pc: r_rsp_pc};

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_next;
  end

  // Credit-gated request, flush and push decisions; FAULT is terminal until reset.
  always_comb begin
    w_state_next = r_state;
    w_req_valid  = 1'b0;
    w_flush      = 1'b0;
    w_rsp_push   = 1'b0;
    case (r_state)
      RUN: begin
        w_req_valid = !rst && !bus.redirect_valid && w_credit;
        w_flush     = bus.redirect_valid;
        w_rsp_push  = bus.imem_rsp_valid && (r_drop_cnt == '0) &&
                      !bus.redirect_valid && !w_fifo_full;
        if (bus.redirect_valid && w_misaligned) w_state_next = FAULT;
      end
      FAULT: w_flush = 1'b1;
    endcase
  end

  // r_rsp_pc tracks the address of the next response that will be kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_redirect_ok) begin
        r_pc       <= bus.redirect_pc;
        r_rsp_pc   <= bus.redirect_pc;
        r_drop_cnt <= w_outstanding_next;
      end else begin
        if (w_accept)   r_pc     <= r_pc + 32'd4;
        if (w_rsp_push) r_rsp_pc <= r_rsp_pc + 32'd4;
        if (bus.imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rsp_push),
    .pop   (bus.instr_ready && !w_fifo_empty),
    .flush (w_flush),
    .wdata (w_wdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count),
    .head  (w_head)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = !w_fifo_empty;
  assign bus.instr          = w_head.instr;
  assign bus.instr_pc       = w_head.pc;
  assign bus.fetch_fault    = (r_state == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: imem model with variable latency, scoreboard on the
// Decode stream, and a second instance exercising PC wrap from a high RESET_PC.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int unsigned DEPTH   = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk (clk), .rst (rst), .bus (bus.master));
  instr_fetch #(.RESET_PC(RST_PC2), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk (clk), .rst (rst2), .bus (bus2.master));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: memory queue, buffered word count, expected streams.
  pend_t       memq[$];
  int          last_due;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          model_buf;
  bit          model_fault;
  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  int          n_acc;
  int          n_pop;
  bit          popped;
  logic [31:0] pop_pc;
  bit          s_rv;
  bit          s_iv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  // One clock of the main DUT: memory response, sampling, scoreboard, model update.
  task automatic run_cycle();
    bit          rsp;
    bit          redir;
    bit          mis;
    bit          exp_rv;
    logic [31:0] rpc;
    pend_t       p;
    int          lat;
    rsp = (memq.size() > 0) && (memq[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'h0;
    #1;
    redir  = bus.redirect_valid;
    rpc    = bus.redirect_pc;
    mis    = (rpc[1:0] != 2'b00);
    s_rv   = bus.imem_req_valid;
    s_iv   = bus.instr_valid;
    popped = 1'b0;
    exp_rv = !model_fault && !redir && ((model_buf + memq.size()) < DEPTH);
    checks++;
    if (s_rv !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, s_rv, exp_rv);
    end
    checks++;
    if (s_iv !== (model_buf > 0)) begin
      errors++;
      $display("FAIL instr_valid cyc=%0d got %b exp %b", cyc, s_iv, (model_buf > 0));
    end
    if (s_iv && bus.instr_ready && !redir) begin
      popped = 1'b1;
      pop_pc = bus.instr_pc;
      n_pop++;
      checks++;
      if (bus.instr_pc !== exp_pc) begin
        errors++;
        $display("FAIL instr_pc cyc=%0d got %h exp %h", cyc, bus.instr_pc, exp_pc);
      end
      checks++;
      if (bus.instr !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL instr cyc=%0d got %h exp %h", cyc, bus.instr, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      if (model_buf > 0) model_buf--;
    end
    if (s_rv && bus.imem_req_ready) begin
      checks++;
      if (bus.imem_req_addr !== exp_addr) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, bus.imem_req_addr, exp_addr);
      end
      lat     = $urandom_range(lat_hi, lat_lo);
      p.addr  = bus.imem_req_addr;
      p.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      p.stale = 1'b0;
      last_due = p.due;
      memq.push_back(p);
      exp_addr = exp_addr + 32'd4;
      n_acc++;
    end
    if (rsp) begin
      p = memq.pop_front();
      if (!p.stale && !redir && !model_fault) model_buf++;
    end
    if (redir && !model_fault) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      model_buf = 0;
      if (mis) model_fault = 1'b1;
      else begin
        exp_pc   = rpc;
        exp_addr = rpc;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      checks++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 ||
          bus.fetch_fault !== 1'b0 || bus.imem_req_addr !== RST_PC) begin
        errors++;
        $display("FAIL reset_vals got rv=%b iv=%b fault=%b addr=%h exp 0 0 0 %h",
                 bus.imem_req_valid, bus.instr_valid, bus.fetch_fault,
                 bus.imem_req_addr, RST_PC);
      end
    end
    rst = 1'b0;
    memq.delete();
    model_buf   = 0;
    model_fault = 1'b0;
    exp_pc      = RST_PC;
    exp_addr    = RST_PC;
    last_due    = cyc;
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    do_reset(2);
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL post_reset_req got rv=%b addr=%h exp 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    int first_iv = -1;
    logic [31:0] first_pc = 32'hDEAD_BEEF;
    lat_lo = 1;
    lat_hi = 1;
    for (int i = 0; i < 24; i++) begin
      run_cycle();
      if (popped && first_iv < 0) begin
        first_iv = i;
        first_pc = pop_pc;
      end
    end
    checks++;
    if (first_iv != 2 || first_pc !== RST_PC) begin
      errors++;
      $display("FAIL first_instr got cycle=%0d pc=%h exp cycle=2 pc=%h", first_iv, first_pc, RST_PC);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    int p0;
    do_reset(2);
    bus.instr_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) run_cycle();
    checks++;
    if ((n_acc - a0) != DEPTH || s_rv !== 1'b0) begin
      errors++;
      $display("FAIL stall_accepts got %0d rv=%b exp %0d rv=0", n_acc - a0, s_rv, DEPTH);
    end
    bus.instr_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 12; i++) run_cycle();
    checks++;
    if ((n_pop - p0) < DEPTH) begin
      errors++;
      $display("FAIL release_pops got %0d exp >=%0d", n_pop - p0, DEPTH);
    end
  endtask

  task automatic test_redirect_drop();
    bit found = 1'b0;
    bit got   = 1'b0;
    lat_lo = 3;
    lat_hi = 3;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (memq.size() == 2 && memq[0].due <= cyc) found = 1'b1;
      else run_cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redirect_setup got none exp two outstanding");
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    run_cycle();
    bus.redirect_valid = 1'b0;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_req got rv=%b addr=%h exp 1 00000100",
               bus.imem_req_valid, bus.imem_req_addr);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      run_cycle();
      got = popped;
    end
    checks++;
    if (!got || pop_pc !== 32'h100) begin
      errors++;
      $display("FAIL redirect_first got pop=%b pc=%h exp 1 00000100", got, pop_pc);
    end
  endtask

  task automatic test_fault();
    bit got = 1'b0;
    lat_lo = 1;
    lat_hi = 2;
    for (int i = 0; i < 4; i++) run_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0102;
    run_cycle();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.fetch_fault !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_hold got fault=%b iv=%b rv=%b exp 1 0 0",
                 bus.fetch_fault, bus.instr_valid, bus.imem_req_valid);
      end
      run_cycle();
    end
    do_reset(1);
    #1;
    checks++;
    if (bus.fetch_fault !== 1'b0 || bus.imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL fault_clear got fault=%b addr=%h exp 0 %h",
               bus.fetch_fault, bus.imem_req_addr, RST_PC);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      run_cycle();
      got = popped;
    end
    checks++;
    if (!got || pop_pc !== RST_PC) begin
      errors++;
      $display("FAIL fault_restart got pop=%b pc=%h exp 1 %h", got, pop_pc, RST_PC);
    end
  endtask

  task automatic test_redirect_collide();
    bit found = 1'b0;
    bit got   = 1'b0;
    lat_lo = 1;
    lat_hi = 1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && model_buf > 0) found = 1'b1;
      else run_cycle();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL collide_setup got none exp rsp with buffered word");
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    run_cycle();
    bus.redirect_valid = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_flush got iv=%b exp 0", bus.instr_valid);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      run_cycle();
      got = popped;
    end
    checks++;
    if (!got || pop_pc !== 32'h200) begin
      errors++;
      $display("FAIL collide_first got pop=%b pc=%h exp 1 00000200", got, pop_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    int p0;
    lat_lo = 1;
    lat_hi = 4;
    p0 = n_pop;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.instr_ready    = ($urandom_range(2, 0) != 0);
      bus.redirect_valid = ($urandom_range(19, 0) == 0);
      bus.redirect_pc    = {r[31:2], 2'b00};
      run_cycle();
    end
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    checks++;
    if ((n_pop - p0) < 50) begin
      errors++;
      $display("FAIL random_throughput got %0d pops exp >=50", n_pop - p0);
    end
  endtask

  task automatic test_reset_mid();
    bit full = 1'b0;
    lat_lo = 1;
    lat_hi = 2;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 20 && !full; i++) begin
      if (model_buf == DEPTH) full = 1'b1;
      else run_cycle();
    end
    checks++;
    if (!full) begin
      errors++;
      $display("FAIL fill_setup got buf=%0d exp %0d", model_buf, DEPTH);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 ||
        bus.fetch_fault !== 1'b0 || bus.imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL midreset got rv=%b iv=%b fault=%b addr=%h exp 0 0 0 %h",
               bus.imem_req_valid, bus.instr_valid, bus.fetch_fault, bus.imem_req_addr, RST_PC);
    end
    do_reset(1);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) run_cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] acc[$];
    logic [31:0] pcs[$];
    logic [31:0] ins[$];
    logic [31:0] exp_seq [3];
    bit          prev_acc = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    exp_seq[0] = 32'hFFFF_FFF8;
    exp_seq[1] = 32'hFFFF_FFFC;
    exp_seq[2] = 32'h0000_0000;
    bus2.imem_req_ready = 1'b1;
    bus2.instr_ready    = 1'b1;
    rst2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus2.imem_rsp_valid = prev_acc;
      bus2.imem_rsp_data  = mem_word(prev_addr);
      #1;
      if (bus2.instr_valid) begin
        pcs.push_back(bus2.instr_pc);
        ins.push_back(bus2.instr);
      end
      prev_acc = bus2.imem_req_valid;
      if (bus2.imem_req_valid) begin
        acc.push_back(bus2.imem_req_addr);
        prev_addr = bus2.imem_req_addr;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus2.imem_rsp_valid = 1'b0;
    checks++;
    if (acc.size() < 3 || pcs.size() < 3) begin
      errors++;
      $display("FAIL wrap_count got acc=%0d pops=%0d exp >=3 each", acc.size(), pcs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (acc[k] !== exp_seq[k] || pcs[k] !== exp_seq[k] || ins[k] !== mem_word(exp_seq[k])) begin
          errors++;
          $display("FAIL wrap_%0d got addr=%h pc=%h instr=%h exp %h %h %h", k, acc[k], pcs[k],
                   ins[k], exp_seq[k], exp_seq[k], mem_word(exp_seq[k]));
        end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = 32'h0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus2.imem_req_ready = 1'b0;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = 32'h0;
    bus2.instr_ready    = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    n_acc = 0;
    n_pop = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_fault();
    test_redirect_collide();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
